// File: rtl/shape_cmd_pkg.sv
// shape_cmd_pkg: packet field widths, offsets and output-stage states for shape_cmd_fifo
package shape_cmd_pkg;
  localparam int SHAPE_ADDR_W = 11;
  localparam int REG_ADDR_W = 12;
  localparam int DATA_W = 12;
  localparam int PKT_W = 35;
  localparam int SHAPE_LSB = 0;
  localparam int REG_LSB = 11;
  localparam int DATA_LSB = 23;
  typedef enum logic {S_EMPTY = 1'b0, S_PRESENT = 1'b1} out_state_e;
endpackage

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem: DEPTH x W storage, registered write, asynchronous read
module sync_fifo_mem #(
  parameter int DEPTH = 16,
  parameter int ADDR_W = 4,
  parameter int W = 35
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [W-1:0]      wd,
  input  logic [ADDR_W-1:0] ra,
  output logic [W-1:0]      rd
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[wa] <= wd;
  assign rd = mem[ra];
endmodule

// File: rtl/shape_cmd_fifo.sv
// shape_cmd_fifo: queues received programming packets and presents them on a valid/ready write port
module shape_cmd_fifo
  import shape_cmd_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int ADDR_W = 4,
  parameter int DROP_CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    program_in,
  input  logic [SHAPE_ADDR_W-1:0] shape_addr_in,
  input  logic [REG_ADDR_W-1:0]   reg_addr_in,
  input  logic [DATA_W-1:0]       data_in,
  output logic                    wr_valid,
  input  logic                    wr_ready,
  output logic [SHAPE_ADDR_W-1:0] wr_shape_addr,
  output logic [REG_ADDR_W-1:0]   wr_reg_addr,
  output logic [DATA_W-1:0]       wr_data,
  output logic [ADDR_W:0]         fifo_count,
  output logic                    full,
  output logic                    overflow,
  output logic [DROP_CNT_W-1:0]   drop_count,
  input  logic                    clr_overflow
);
  logic [ADDR_W-1:0] rd_ptr, wr_ptr;
  logic [PKT_W-1:0] pkt_in, mem_rd, head, head_nx;
  out_state_e state, state_nx;
  logic push, pop, drop;
  assign pkt_in = {data_in, reg_addr_in, shape_addr_in};
  assign wr_valid = state == S_PRESENT;
  assign full = fifo_count == (ADDR_W+1)'(DEPTH);
  assign pop = wr_valid & wr_ready;
  assign push = program_in & (~full | pop);
  assign drop = program_in & full & ~pop;
  assign wr_shape_addr = head[SHAPE_LSB +: SHAPE_ADDR_W];
  assign wr_reg_addr = head[REG_LSB +: REG_ADDR_W];
  assign wr_data = head[DATA_LSB +: DATA_W];
  sync_fifo_mem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .W(PKT_W)) u_mem (
    .clk(clk),
    .we (push),
    .wa (wr_ptr),
    .wd (pkt_in),
    .ra (rd_ptr + ADDR_W'(1)),
    .rd (mem_rd)
  );
  // The head lives both in the output register and at mem[rd_ptr]; on a pop the successor
  // comes from mem[rd_ptr+1], or straight from the input when the queue would drain.
  always_comb begin
    state_nx = state;
    head_nx = head;
    if (state == S_EMPTY) begin
      state_nx = push ? S_PRESENT : S_EMPTY;
      head_nx = push ? pkt_in : head;
    end else if (pop) begin
      state_nx = (fifo_count > (ADDR_W+1)'(1) || push) ? S_PRESENT : S_EMPTY;
      head_nx = fifo_count > (ADDR_W+1)'(1) ? mem_rd : push ? pkt_in : head;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_EMPTY;
      head <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      fifo_count <= '0;
      overflow <= 1'b0;
      drop_count <= '0;
    end else begin
      state <= state_nx;
      head <= head_nx;
      rd_ptr <= pop ? rd_ptr + ADDR_W'(1) : rd_ptr;
      wr_ptr <= push ? wr_ptr + ADDR_W'(1) : wr_ptr;
      fifo_count <= fifo_count + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
      overflow <= drop | (overflow & ~clr_overflow);
      drop_count <= drop ? (clr_overflow ? DROP_CNT_W'(1) : &drop_count ? drop_count : drop_count + DROP_CNT_W'(1))
                         : clr_overflow ? '0 : drop_count;
    end
  end
endmodule
